// File: rtl/spi_prog_tx.sv
// Serial program-loader transmitter: takes 32-bit words over valid/ready and
// frames each one MSB-first on spi_ss/spi_mosi for the SoC boot loader.
module spi_prog_tx #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] END_WORD   = 32'h00000fff,
    parameter int                    GAP_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    output logic                  spi_ss_o,
    output logic                  spi_mosi_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           word_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [5:0]  BIT_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    accept_s;
    logic                    clear_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [5:0]              bit_cnt_r;
    logic [15:0]             gap_cnt_r;
    logic                    is_end_r;
    logic [15:0]             word_cnt_r;
    logic                    ss_r;
    logic                    mosi_r;
    logic                    busy_r;
    logic                    done_r;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus word-accept and counter-clear strobes
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    next_state_s = ST_WAIT;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (word_valid_i) begin
                    next_state_s = ST_SETUP;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_r != BIT_LAST) begin
                    next_state_s = ST_SHIFT;
                end else if (GAP_CYCLES != 0) begin
                    next_state_s = ST_GAP;
                end else if (is_end_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != GAP_LAST) begin
                    next_state_s = ST_GAP;
                end else if (is_end_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    next_state_s = ST_WAIT;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; outputs are computed from the next
    // state so that spi_ss falls on the accepting edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_r    <= '0;
            bit_cnt_r  <= 6'd0;
            gap_cnt_r  <= 16'd0;
            is_end_r   <= 1'b0;
            word_cnt_r <= 16'd0;
            ss_r       <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                shift_r  <= word_i;
                is_end_r <= (word_i == END_WORD);
            end else if (next_state_s == ST_SHIFT) begin
                shift_r  <= shift_r << 1;
            end

            bit_cnt_r <= (state_r == ST_SHIFT) ? bit_cnt_r + 6'd1 : 6'd0;
            gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + 16'd1 : 16'd0;

            if (clear_s) begin
                word_cnt_r <= 16'd0;
            end else if (accept_s && (word_cnt_r != 16'hFFFF)) begin
                word_cnt_r <= word_cnt_r + 16'd1;
            end

            ss_r   <= !((next_state_s == ST_SETUP) || (next_state_s == ST_SHIFT));
            mosi_r <= (next_state_s == ST_SHIFT) ? shift_r[DATA_WIDTH-1] : 1'b0;
            busy_r <= (next_state_s != ST_IDLE) && (next_state_s != ST_DONE);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign word_ready_o = (state_r == ST_WAIT);
    assign spi_ss_o     = ss_r;
    assign spi_mosi_o   = mosi_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign word_cnt_o   = word_cnt_r;

endmodule

// File: tb/tb_spi_prog_tx.sv
// Directed bench for spi_prog_tx: default build (dut0) and GAP_CYCLES=3 build (dut3).
module tb_spi_prog_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [31:0] word;
    logic        sel;

    logic        ready0, ss0, mosi0, busy0, done0;
    logic [15:0] cnt0;
    logic        ready3, ss3, mosi3, busy3, done3;
    logic [15:0] cnt3;

    logic        ready_m, ss_m, mosi_m, busy_m, done_m;
    logic [15:0] cnt_m;

    int          n_checks;
    int          n_errors;
    logic [31:0] q[$];
    logic        acc_pending;

    logic [31:0] w;
    int          hi;
    int          len;
    logic        lead;
    logic        tail;
    logic        flag;
    int          t;

    always #5 clk = ~clk;

    spi_prog_tx dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start & ~sel),
        .word_i       (word),
        .word_valid_i (valid & ~sel),
        .word_ready_o (ready0),
        .spi_ss_o     (ss0),
        .spi_mosi_o   (mosi0),
        .busy_o       (busy0),
        .done_o       (done0),
        .word_cnt_o   (cnt0)
    );

    spi_prog_tx #(.GAP_CYCLES(3)) dut3 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start & sel),
        .word_i       (word),
        .word_valid_i (valid & sel),
        .word_ready_o (ready3),
        .spi_ss_o     (ss3),
        .spi_mosi_o   (mosi3),
        .busy_o       (busy3),
        .done_o       (done3),
        .word_cnt_o   (cnt3)
    );

    assign ready_m = sel ? ready3 : ready0;
    assign ss_m    = sel ? ss3    : ss0;
    assign mosi_m  = sel ? mosi3  : mosi0;
    assign busy_m  = sel ? busy3  : busy0;
    assign done_m  = sel ? done3  : done0;
    assign cnt_m   = sel ? cnt3   : cnt0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts ss-high cycles, then collects one frame; start_at pulses start_i at that low cycle.
    task automatic recv_frame(input int start_at);
        hi = 0; len = 0; w = 32'd0; lead = 1'b1;
        while (ss_m === 1'b1 && hi < 400) begin
            hi++;
            tick();
        end
        if (ss_m !== 1'b0) check_val("ss_fall", {31'd0, ss_m}, 32'd0);
        while (ss_m === 1'b0 && len < 64) begin
            if (len == 0) lead = mosi_m;
            else w = {w[30:0], mosi_m};
            start = (len == start_at);
            len++;
            tick();
        end
        start = 1'b0;
        tail = mosi_m;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp);
        check_val({tag, "_word"}, w, exp);
        check_val({tag, "_len"}, len, 32'd33);
        check_val({tag, "_lead"}, {31'd0, lead}, 32'd0);
        check_val({tag, "_tail"}, {31'd0, tail}, 32'd0);
    endtask

    // Word source: presents the queue head and pops it after an accepting edge.
    initial begin
        valid = 1'b0;
        word = 32'd0;
        acc_pending = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (acc_pending && rst_n && q.size() > 0) void'(q.pop_front());
            if (q.size() > 0) begin
                valid = 1'b1;
                word  = q[0];
            end else begin
                valid = 1'b0;
            end
            acc_pending = valid && ready_m;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 1'b0;
        n_checks = 0; n_errors = 0;
        #12;
        check_val("rst_ss",    {31'd0, ss0},    32'd1);
        check_val("rst_mosi",  {31'd0, mosi0},  32'd0);
        check_val("rst_ready", {31'd0, ready0}, 32'd0);
        check_val("rst_busy",  {31'd0, busy0},  32'd0);
        check_val("rst_done",  {31'd0, done0},  32'd0);
        check_val("rst_cnt",   {16'd0, cnt0},   32'd0);
        check_val("rst_ss3",   {31'd0, ss3},    32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single word then terminator
        pulse_start();
        q.push_back(32'hA5A50001);
        q.push_back(32'h00000FFF);
        recv_frame(-1);
        check_frame("t1_f1", 32'hA5A50001);
        recv_frame(-1);
        check_val("t1_gap", hi, 32'd1);
        check_frame("t1_f2", 32'h00000FFF);
        check_val("t1_done",  {31'd0, done_m},  32'd1);
        check_val("t1_busy",  {31'd0, busy_m},  32'd0);
        check_val("t1_ready", {31'd0, ready_m}, 32'd0);
        check_val("t1_cnt",   {16'd0, cnt_m},   32'd2);

        // Restart from DONE, ignored start mid-shift, back-pressure
        pulse_start();
        check_val("t2_done_clr", {31'd0, done_m},  32'd0);
        check_val("t2_cnt_clr",  {16'd0, cnt_m},   32'd0);
        check_val("t2_ready",    {31'd0, ready_m}, 32'd1);
        q.push_back(32'h3C0FF00D);
        recv_frame(10);
        check_frame("t2_f1", 32'h3C0FF00D);
        check_val("t2_cnt1", {16'd0, cnt_m}, 32'd1);
        flag = 1'b1;
        for (int i = 0; i < 7; i++) begin
            flag &= ready_m;
            tick();
        end
        flag &= ready_m;
        q.push_back(32'h80000001);
        recv_frame(-1);
        check_val("t2_bp_gap", 7 + hi, 32'd8);
        check_val("t2_bp_ready", {31'd0, flag}, 32'd1);
        check_frame("t2_f2", 32'h80000001);
        q.push_back(32'h00000FFF);
        recv_frame(-1);
        check_frame("t2_f3", 32'h00000FFF);
        check_val("t2_done", {31'd0, done_m}, 32'd1);
        check_val("t2_cnt",  {16'd0, cnt_m},  32'd3);

        // Reset in the middle of SHIFT
        pulse_start();
        q.push_back(32'hDEADBEEF);
        t = 0;
        while (ss_m === 1'b1 && t < 50) begin
            t++;
            tick();
        end
        for (int i = 0; i < 11; i++) tick();
        check_val("t3_pre_ss",   {31'd0, ss_m},   32'd0);
        check_val("t3_pre_mosi", {31'd0, mosi_m}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t3_async_ss",   {31'd0, ss_m},   32'd1);
        check_val("t3_async_mosi", {31'd0, mosi_m}, 32'd0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t3_cnt",   {16'd0, cnt_m},   32'd0);
        check_val("t3_busy",  {31'd0, busy_m},  32'd0);
        check_val("t3_ready", {31'd0, ready_m}, 32'd0);
        q.push_back(32'h5A5A5A5A);
        flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            flag &= ss_m;
            tick();
        end
        check_val("t3_idle_ss",  {31'd0, flag},  32'd1);
        check_val("t3_idle_cnt", {16'd0, cnt_m}, 32'd0);
        pulse_start();
        recv_frame(-1);
        check_frame("t3_f1", 32'h5A5A5A5A);
        q.push_back(32'h00000FFF);
        recv_frame(-1);
        check_val("t3_done", {31'd0, done_m}, 32'd1);

        // Start and valid together in DONE, then a 32-word load
        for (int i = 0; i < 31; i++) q.push_back(32'h10000000 + 32'(i));
        q.push_back(32'h00000FFF);
        pulse_start();
        check_val("t4_cnt0",  {16'd0, cnt_m},   32'd0);
        check_val("t4_ready", {31'd0, ready_m}, 32'd1);
        check_val("t4_done0", {31'd0, done_m},  32'd0);
        for (int i = 0; i < 32; i++) begin
            recv_frame(-1);
            check_val("t4_gap", hi, 32'd1);
            check_frame("t4_f", (i == 31) ? 32'h00000FFF : 32'h10000000 + 32'(i));
        end
        check_val("t4_cnt",  {16'd0, cnt_m},  32'd32);
        check_val("t4_done", {31'd0, done_m}, 32'd1);

        // GAP_CYCLES=3 build; 0xFFE must not terminate
        sel = 1'b1;
        tick();
        pulse_start();
        q.push_back(32'h11112222);
        q.push_back(32'h00000FFE);
        q.push_back(32'h00000FFF);
        recv_frame(-1);
        check_frame("t5_f1", 32'h11112222);
        recv_frame(-1);
        check_val("t5_gap1", hi, 32'd4);
        check_frame("t5_f2", 32'h00000FFE);
        recv_frame(-1);
        check_val("t5_gap2", hi, 32'd4);
        check_frame("t5_f3", 32'h00000FFF);
        check_val("t5_done_gap", {31'd0, done_m}, 32'd0);
        tick();
        tick();
        tick();
        check_val("t5_done", {31'd0, done_m}, 32'd1);
        check_val("t5_busy", {31'd0, busy_m}, 32'd0);
        check_val("t5_cnt",  {16'd0, cnt_m},  32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
